// File: rtl/pdm_audio_loop.sv
// pdm_audio_loop: PDM mic capture, sample FIFO and PWM playback in a single clock domain.
module pdm_audio_loop #(
    parameter int CLK_DIV = 50,
    parameter int DECIM = 64,
    parameter int DEPTH = 256,
    parameter bit LR_SEL = 1'b0,
    localparam int SW = $clog2(DECIM) + 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mclk,
    output logic          micLRSel,
    input  logic          micData,
    output logic          ampPWM,
    output logic          ampSD,
    input  logic          rec_en,
    input  logic          play_en,
    input  logic          mute,
    input  logic          status_clr,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow,
    output logic [AW:0]   level
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [SW-1:0] MID = SW'(DECIM / 2);
    localparam logic [SW-2:0] LAST = (SW-1)'(DECIM - 1);

    logic [DW-1:0] div_cnt;
    logic          wrap, bit_tick;
    logic [SW-2:0] bit_cnt, frame_cnt;
    logic [SW-1:0] ones, sample, duty;
    logic [SW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          push, pop, push_ok, pop_ok, run;

    assign micLRSel = LR_SEL;
    assign ampSD    = play_en;
    assign wrap     = div_cnt == DW'(CLK_DIV - 1);
    // the event edge is the wrap cycle whose mclk value is about to flip away from LR_SEL
    assign bit_tick = wrap && (mclk == LR_SEL);
    assign sample   = ones + SW'(micData);
    assign push     = bit_tick && rec_en && bit_cnt == LAST;
    assign pop      = bit_tick && play_en && (!run || frame_cnt == LAST);
    assign empty    = level == '0;
    assign full     = level == (AW+1)'(DEPTH);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            mclk    <= 1'b0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + 1'b1;
            if (wrap) mclk <= !mclk;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            ones    <= '0;
        end else if (!rec_en) begin
            bit_cnt <= '0;
            ones    <= '0;
        end else if (bit_tick) begin
            bit_cnt <= bit_cnt + 1'b1;
            ones    <= push ? '0 : sample;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= sample;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok) rp <= rp + 1'b1;
            level     <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            overflow  <= (push && !push_ok) || (overflow && !status_clr);
            underflow <= (pop && empty) || (underflow && !status_clr);
        end
    end

    // run marks that the first frame boundary after play_en rose has been taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
            duty      <= MID;
            run       <= 1'b0;
            ampPWM    <= 1'b0;
        end else begin
            ampPWM <= play_en && run && ({1'b0, frame_cnt} < duty);
            if (!play_en) begin
                frame_cnt <= '0;
                run       <= 1'b0;
            end else if (bit_tick) begin
                frame_cnt <= run ? frame_cnt + 1'b1 : '0;
                run       <= 1'b1;
            end
            if (pop) duty <= (mute || empty) ? MID : mem[rp];
        end
    end
endmodule

// File: tb/tb_pdm_audio_loop.sv
// tb_pdm_audio_loop: randomized scoreboard bench for pdm_audio_loop against an event-level model.
module tb_pdm_audio_loop;
    localparam int DECIM = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0, reset = 1'b0, micData = 1'b0, rec_en = 1'b0, play_en = 1'b0;
    logic mute = 1'b0, status_clr = 1'b0;
    logic mclk, micLRSel, ampPWM, ampSD, empty, full, overflow, underflow;
    logic [2:0] level;

    int checks = 0, passed = 0, frames_done = 0, last_duty = -1;
    int mq[$];
    int sq[$];
    logic pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    pdm_audio_loop #(.CLK_DIV(2), .DECIM(DECIM), .DEPTH(DEPTH), .LR_SEL(1'b0)) dut (
        .clk(clk), .reset(reset), .mclk(mclk), .micLRSel(micLRSel), .micData(micData),
        .ampPWM(ampPWM), .ampSD(ampSD), .rec_en(rec_en), .play_en(play_en), .mute(mute),
        .status_clr(status_clr), .empty(empty), .full(full), .overflow(overflow),
        .underflow(underflow), .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: one step per mclk rise, using the inputs the DUT saw at that edge.
    logic pm = 1'b0, rec_d = 1'b0, mic_d = 1'b0, play_d = 1'b0, mute_d = 1'b0, clr_d = 1'b0;
    bit ovf, unf, started, mpop, mpush;
    int ones, bits, fc, d, smp;
    logic [8:0] av, ev;
    logic [2:0] lv;

    always @(negedge clk) begin
        if (!reset) begin
            mq.delete(); sq.delete();
            ovf = 0; unf = 0; ones = 0; bits = 0; fc = 0; started = 0;
        end else begin
            if (clr_d) begin ovf = 0; unf = 0; end
            if (!play_d) begin sq.delete(); started = 0; fc = 0; end
            if (!rec_d) begin ones = 0; bits = 0; end
            if (mclk && !pm) begin
                mpop = 0; mpush = 0;
                if (play_d) begin
                    if (!started) begin started = 1; mpop = 1; end
                    else begin fc = (fc + 1) % DECIM; mpop = (fc == 0); end
                end
                if (rec_d) begin
                    ones += int'(mic_d); bits++;
                    if (bits == DECIM) begin mpush = 1; smp = ones; ones = 0; bits = 0; end
                end
                if (mpop) begin
                    if (mq.size() == 0) begin unf = 1; d = DECIM / 2; end
                    else d = mq.pop_front();
                    if (mute_d) d = DECIM / 2;
                    sq.delete(); sq.push_back(d);
                end
                if (mpush) begin
                    if (mq.size() < DEPTH) mq.push_back(smp);
                    else ovf = 1;
                end
            end
        end
        lv = 3'(mq.size());
        av = {level, full, empty, overflow, underflow, ampSD, play_d ? 1'b0 : ampPWM};
        ev = {lv, lv == 3'd4, lv == 3'd0, ovf, unf, play_en, 1'b0};
        chk("status", int'(av), int'(ev));
        pm = mclk; rec_d = rec_en; mic_d = micData; play_d = play_en; mute_d = mute; clr_d = status_clr;
    end

    // Monitor: one ampPWM sample per bit period (at mclk fall), compared per completed frame.
    logic mpm = 1'b0, mpd = 1'b0;
    int mb, mo;
    always @(negedge clk) begin
        if (!reset || !mpd) begin
            mb = 0; mo = 0;
        end else if (!mclk && mpm && sq.size() != 0) begin
            mb++; mo += int'(ampPWM);
            if (mb == DECIM) begin
                chk("duty", mo, sq.pop_front());
                last_duty = mo; frames_done++; mb = 0; mo = 0;
            end
        end
        mpm = mclk; mpd = play_en;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            do begin @(posedge clk); #1; t++; end while (mclk && t < 20);
            do begin @(posedge clk); #1; t++; end while (!mclk && t < 20);
            if (t >= 20) begin checks++; $display("FAIL mclk_timeout: got no rise expected rise at %0t", $time); end
        end
    endtask

    task automatic wait_frames(input int n);
        int target = frames_done + n;
        int t = 0;
        while (frames_done < target && t < 40 * n + 100) begin @(posedge clk); #1; t++; end
        if (frames_done < target) begin checks++; $display("FAIL frame_timeout: got %0d frames expected %0d", frames_done, target); end
    endtask

    task automatic pulse_clr;
        @(posedge clk); #1; status_clr = 1'b1;
        @(posedge clk); #1; status_clr = 1'b0;
    endtask

    task automatic release_chk;
        int n = 0;
        @(posedge clk); #1; reset = 1'b1;
        do begin @(posedge clk); #1; n++; end while (!mclk && n < 10);
        chk("first_rise", n, 2);
    endtask

    task automatic reset_chk;
        @(negedge clk);
        chk("rst_mclk", int'(mclk), 0);
        chk("rst_pwm", int'(ampPWM), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_flags", int'({overflow, underflow}), 0);
        @(posedge clk); #1; play_en = 1'b0; rec_en = 1'b0; mute = 1'b0;
        release_chk();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        play_en = 1'b1; rec_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset_chk();

        rec_en = 1'b1;
        for (int i = 0; i < 8; i++) begin micData = pat[i]; tick(1); end
        rec_en = 1'b0;
        chk("cap_level", int'(level), 1);
        play_en = 1'b1; wait_frames(1); play_en = 1'b0;
        chk("cap_duty", last_duty, 4);
        pulse_clr();

        micData = 1'b1; rec_en = 1'b1;
        tick(32);
        chk("pre_ovf", int'(overflow), 0);
        tick(8);
        rec_en = 1'b0;
        chk("full_level", int'(level), 4);
        chk("full_flag", int'(full), 1);
        chk("ovf_set", int'(overflow), 1);
        pulse_clr();
        chk("ovf_clr", int'(overflow), 0);

        rec_en = 1'b1;
        for (int i = 0; i < 7; i++) begin micData = 1'($urandom_range(0, 1)); tick(1); end
        play_en = 1'b1; micData = 1'($urandom_range(0, 1));
        tick(1);
        rec_en = 1'b0;
        chk("pp_level", int'(level), 4);
        chk("pp_ovf", int'(overflow), 0);
        wait_frames(6); play_en = 1'b0;
        chk("drain_unf", int'(underflow), 1);
        pulse_clr();
        chk("unf_clr", int'(underflow), 0);

        begin
            int a = $urandom_range(0, 7);
            int b = (a + $urandom_range(1, 7)) % 8;
            rec_en = 1'b1;
            micData = 1'b1; tick(8);
            micData = 1'b0; tick(8);
            for (int i = 0; i < 8; i++) begin micData = (i == a || i == b); tick(1); end
            rec_en = 1'b0;
        end
        chk("pre_level", int'(level), 3);
        play_en = 1'b1; wait_frames(4); play_en = 1'b0;
        chk("play_unf", int'(underflow), 1);
        chk("play_last", last_duty, 4);
        pulse_clr();

        rec_en = 1'b1; micData = 1'b1; tick(8); rec_en = 1'b0;
        mute = 1'b1; play_en = 1'b1;
        wait_frames(1);
        chk("mute_duty", last_duty, 4);
        chk("mute_level", int'(level), 0);
        play_en = 1'b0; mute = 1'b0;
        pulse_clr();

        for (int i = 0; i < 300; i++) begin
            micData = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) rec_en = !rec_en;
            if ($urandom_range(0, 31) == 0) play_en = !play_en;
            if ($urandom_range(0, 31) == 0) mute = !mute;
            status_clr = ($urandom_range(0, 19) == 0);
            tick(1);
        end
        status_clr = 1'b0;

        play_en = 1'b1; rec_en = 1'b1; mute = 1'b0;
        tick(11);
        @(posedge clk); #1; reset = 1'b0; play_en = 1'b1;
        reset_chk();
        tick(2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
